rr_arb4_16: RTL
===============

// Module: rr_arb4_16
// PURPOSE
//  Upstream stage of Mux4Way16: arbitrates four 16-bit valid/ready sources and drives sel_i.
//  Round-robin (or fixed-priority) grant picks a source; the selected word is routed through
//  a Mux4Way16 instance and captured in a one-entry output register with a valid/ready handshake.
//  Used wherever the datapath merges four 16-bit producers onto one bus (e.g. RAM/CPU write-back).
// PARAMETERS
//  PRIO_MODE  0   0 = round-robin, 1 = fixed priority (src 0 highest, 3 lowest)
//  DATA_W     16  data width; fixed at 16 to match Mux4Way16; any other value is illegal
// PORTS
//  clk_i        in   1   clock, all state on rising edge
//  rst_n_i      in   1   asynchronous reset, active low
//  a_i..d_i     in   16  source 0..3 data (each a separate port)
//  valid_i      in   4   bit k: source k presents a word
//  ready_o      out  4   bit k: source k word accepted this cycle (one-hot or zero)
//  out_o        out  16  registered output word
//  src_o        out  2   index of source that produced out_o
//  out_valid_o  out  1   out_o/src_o valid
//  out_ready_i  in   1   consumer takes out_o when out_valid_o & out_ready_i
//  sel_o        out  2   current grant index (= sel_i of internal Mux4Way16), combinational
// BEHAVIOUR
//  Reset (async, rst_n_i=0): out_o=0, src_o=0, out_valid_o=0, ptr=2'd3 (src 0 first). ready_o=0.
//  Register state: out_o, src_o, out_valid_o, ptr[1:0] (last granted index).
//  can_load = !out_valid_o | out_ready_i  (empty, or draining this cycle).
//  Grant (combinational): RR searches ptr+1, ptr+2, ptr+3, ptr (mod 4) for first valid_i bit;
//   PRIO_MODE=1 searches 0,1,2,3. sel_o = grant index; sel_o = ptr when no valid_i.
//  ready_o[k] = can_load & any(valid_i) & (grant==k); ready_o never depends on out_valid_o alone
//   transitions beyond can_load. Transfer on source k = valid_i[k] & ready_o[k].
//  On transfer: next edge out_o <= mux(sel_o) word, src_o <= grant, out_valid_o <= 1, ptr <= grant.
//  Drain with no transfer: out_valid_o <= 0; out_o/src_o hold last value.
//  Simultaneous drain + transfer: out_valid_o stays 1, new word replaces old; throughput 1 word/clk.
//  Stalled (out_valid_o & !out_ready_i): ready_o=0, out_o/src_o/ptr hold, no word lost or duplicated.
//  Latency: accept on edge N -> out_valid_o with that word from edge N (visible cycle N+1).
//  Ptr wrap: 3 -> 0 is modulo-4; no special case. ptr unchanged when no transfer.
//  Fairness (RR): a source held valid is granted within 4 consecutive transfers.
//  Sources must hold data stable while valid_i=1 and not yet accepted; block does not check.
//  Reset mid-operation: held word discarded, ptr reset; first grant after release follows reset ptr.
//  valid_i deassert without transfer is legal and simply removes the request.
// STRUCTURE
//  Shared package/include: SRC_A=2'd0..SRC_D=2'd3 source encodings, PRIO_RR/PRIO_FIXED constants.
//  Sub-module: one Mux4Way16 instance (a_i..d_i, sel_i=sel_o) for the data path; grant logic,
//  pointer and output register local. No other hierarchy.
// TESTING
//  1 reset: rst_n_i=0 mid-stream -> out_valid_o=0, out_o=16'h0000, ready_o=4'b0000 immediately.
//  2 RR all busy: valid_i=4'b1111, a=16'h1234 b=16'h9876 c=16'hAAAA d=16'h5555, out_ready_i=1
//    -> src_o sequence 0,1,2,3,0; out_o 1234,9876,AAAA,5555,1234 on consecutive cycles.
//  3 backpressure: out_ready_i=0 after first accept -> ready_o=0, out_o=16'h1234 held 5 cycles;
//    release -> next word 16'h9876 from src 1, no loss/duplication.
//  4 sparse: valid_i=4'b1000 only, d=16'h5555 -> ready_o=4'b1000, src_o=3; then ptr=3 and
//    valid_i=4'b1001 -> src 0 granted first (wrap 3->0).
//  5 PRIO_MODE=1, valid_i=4'b0110 held -> src 1 every transfer, src 2 starved; valid_i=0 ->
//    out_valid_o drops one cycle after final drain.
//  6 scoreboard: random valid/ready 2000 cycles -> every accepted word appears once, in order,
//    with correct src_o; RR source wait <= 4 transfers.

Source files
------------

// File: rtl/rr_arb4_16_pkg.sv
// Shared encodings and grant search for the four-source 16-bit arbiter.
// The arbiter and its mux both import this package.
package rr_arb4_16_pkg;

    localparam logic [1:0] SRC_A = 2'd0;
    localparam logic [1:0] SRC_B = 2'd1;
    localparam logic [1:0] SRC_C = 2'd2;
    localparam logic [1:0] SRC_D = 2'd3;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    localparam int MUX_W = 16;

    // Candidates are visited from farthest to nearest so the last hit is the winner.
    // Round-robin order is ptr+1, ptr+2, ptr+3, ptr. Fixed order is 0, 1, 2, 3.
    function automatic logic [1:0] pick_grant(input logic [3:0] req,
                                              input logic [1:0] ptr,
                                              input logic       fixed_prio);
        logic [1:0] idx;
        logic [1:0] g;
        g = ptr;
        for (int off = 4; off >= 1; off--) begin
            idx = fixed_prio ? 2'(off - 1) : ptr + 2'(off);
            if (req[idx]) g = idx;
        end
        return g;
    endfunction

endpackage

// File: rtl/rr_arb4_16_mux4way16.sv
// Mux4Way16: selects one of four 16-bit words.
// sel_i uses the SRC_x source encoding.
module mux4way16
    import rr_arb4_16_pkg::*;
(
    input  logic [MUX_W-1:0] a_i,
    input  logic [MUX_W-1:0] b_i,
    input  logic [MUX_W-1:0] c_i,
    input  logic [MUX_W-1:0] d_i,
    input  logic [1:0]       sel_i,
    output logic [MUX_W-1:0] out_o
);

    always_comb begin
        case (sel_i)
            SRC_A:   out_o = a_i;
            SRC_B:   out_o = b_i;
            SRC_C:   out_o = c_i;
            default: out_o = d_i;
        endcase
    end

endmodule

// File: rtl/rr_arb4_16.sv
// Four-source valid/ready arbiter feeding a Mux4Way16.
// The selected word is held in a one-entry output register.
module rr_arb4_16
    import rr_arb4_16_pkg::*;
#(
    parameter int PRIO_MODE = PRIO_RR,
    parameter int DATA_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] c_i,
    input  logic [DATA_W-1:0] d_i,
    input  logic [3:0]        valid_i,
    output logic [3:0]        ready_o,
    output logic [DATA_W-1:0] out_o,
    output logic [1:0]        src_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [1:0]        sel_o
);

    if (DATA_W != MUX_W) begin : g_bad_width
        $error("rr_arb4_16: DATA_W must be 16 to match Mux4Way16");
    end

    localparam logic FIXED_PRIO = (PRIO_MODE == PRIO_FIXED);

    logic [DATA_W-1:0] out_q, out_d;
    logic [1:0]        src_q, src_d;
    logic              out_valid_q, out_valid_d;
    logic [1:0]        ptr_q, ptr_d;

    logic [1:0]        grant;
    logic              any_valid;
    logic              can_load;
    logic              xfer;
    logic [DATA_W-1:0] mux_word;

    assign any_valid = |valid_i;
    assign can_load  = !out_valid_q || out_ready_i;
    assign xfer      = can_load && any_valid;
    assign grant     = pick_grant(valid_i, ptr_q, FIXED_PRIO);

    mux4way16 u_mux (
        .a_i   (a_i),
        .b_i   (b_i),
        .c_i   (c_i),
        .d_i   (d_i),
        .sel_i (grant),
        .out_o (mux_word)
    );

    // Ready is gated by reset so that no source sees an accept while the block is held in reset.
    assign ready_o = (rst_n_i && xfer) ? (4'b0001 << grant) : 4'b0000;
    assign sel_o   = grant;

    always_comb begin
        out_d       = out_q;
        src_d       = src_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_d       = mux_word;
            src_d       = grant;
            out_valid_d = 1'b1;
            ptr_d       = grant;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_q       <= '0;
            src_q       <= SRC_A;
            out_valid_q <= 1'b0;
            ptr_q       <= SRC_D;
        end else begin
            out_q       <= out_d;
            src_q       <= src_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_o       = out_q;
    assign src_o       = src_q;
    assign out_valid_o = out_valid_q;

endmodule
